// File: rtl/md5_candidate_gen_if.sv
// Message stream between the candidate generator and the MD5 pipeline.
// The generator is the master: it drives the 128-bit message field and its
// new_message strobe. The pipeline side is the slave: it drives en, which
// throttles the generator.
interface md5_candidate_gen_if;
  logic [127:0] message;
  logic         new_message;
  logic         en;

  modport master (output message, output new_message, input en);
  modport slave  (input message, input new_message, output en);
endinterface

// File: rtl/md5_candidate_gen.sv
// Brute-force candidate generator feeding the 64-stage MD5 pipeline.
// An odometer over a fixed charset walks every string of length start_len
// up to MAX_LEN. One padded candidate is emitted per enabled cycle.
// Byte i of the field sits in word i/4 at bits [8*(i%4)+7 : 8*(i%4)], so
// byte 0 is the low byte of W0 (MD5 little-endian). The length field is
// left to the pipeline's zero region.
// Optional macro MD5_CANDIDATE_DIGITS_EN extends the charset with '0'..'9'
// after 'z' (36 symbols). When it is undefined, only 'a'..'z' are used.
module md5_candidate_gen #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 48
) (
  input  logic                clk,
  input  logic                rst,
  md5_candidate_gen_if.master bus,
  input  logic                start,
  input  logic [3:0]          start_len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [3:0]          cur_len,
  output logic [CNT_W-1:0]    count
);

`ifdef MD5_CANDIDATE_DIGITS_EN
  localparam int DIGIT_W = 6;
  localparam logic [DIGIT_W-1:0] LAST_SYM = 6'd35;
`else
  localparam int DIGIT_W = 5;
  localparam logic [DIGIT_W-1:0] LAST_SYM = 5'd25;
`endif

  localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [DIGIT_W-1:0] digits     [MAX_LEN];
  logic [DIGIT_W-1:0] digits_inc [MAX_LEN];
  logic [3:0]         len;
  logic [3:0]         len_clamped;
  logic               carry_out;
  logic               exhausted;
  logic [127:0]       candidate;

  // Map a charset index to its ASCII character.
  function automatic logic [7:0] sym_char(input logic [DIGIT_W-1:0] idx);
`ifdef MD5_CANDIDATE_DIGITS_EN
    if (idx >= 6'd26) return 8'h30 + 8'(idx - 6'd26);
`endif
    return 8'h61 + 8'(idx);
  endfunction

  assign len_clamped = (start_len == 4'd0)     ? 4'd1      :
                       (start_len > MAX_LEN_L) ? MAX_LEN_L : start_len;

  assign busy = (state == RUN);

  // Assemble the padded candidate field from the current digits and length.
  always_comb begin
    candidate = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) candidate[96 - 32*(i/4) + 8*(i%4) +: 8] = sym_char(digits[i]);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == int'(len)) candidate[96 - 32*(i/4) + 8*(i%4) +: 8] = 8'h80;
    end
  end

  // Ripple increment of the odometer; carry_out means every active digit wrapped.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      digits_inc[i] = digits[i];
      if (carry && (i < int'(len))) begin
        if (digits[i] == LAST_SYM) begin
          digits_inc[i] = '0;
        end else begin
          digits_inc[i] = digits[i] + 1'b1;
          carry         = 1'b0;
        end
      end
    end
    carry_out = carry;
  end

  // Control FSM: start/abort handling, emission, odometer advance and done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      bus.message     <= '0;
      bus.new_message <= 1'b0;
      done            <= 1'b0;
      cur_len         <= 4'd0;
      count           <= '0;
      len             <= 4'd0;
      exhausted       <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) digits[i] <= '0;
    end else if (abort) begin
      state           <= IDLE;
      bus.new_message <= 1'b0;
      done            <= 1'b0;
      exhausted       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          bus.new_message <= 1'b0;
          if (start) begin
            state     <= RUN;
            len       <= len_clamped;
            count     <= '0;
            done      <= 1'b0;
            exhausted <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) digits[i] <= '0;
          end
        end
        RUN: begin
          if (exhausted) begin
            state           <= DONE;
            done            <= 1'b1;
            bus.new_message <= 1'b0;
            exhausted       <= 1'b0;
          end else if (bus.en) begin
            bus.message     <= candidate;
            bus.new_message <= 1'b1;
            cur_len         <= len;
            if (count != '1) count <= count + CNT_W'(1);
            for (int i = 0; i < MAX_LEN; i++) digits[i] <= digits_inc[i];
            if (carry_out) begin
              if (len == MAX_LEN_L) exhausted <= 1'b1;
              else                  len       <= len + 4'd1;
            end
          end else begin
            bus.new_message <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
